// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    localparam logic [1:0] DT_BYTE = 2'd0;
    localparam logic [1:0] DT_HALF = 2'd1;
    localparam logic [1:0] DT_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } st_e;

    // Codes 2 and 3 both mean word.
    function automatic logic misaligned(input logic [1:0] dt, input logic [1:0] a);
        case (dt)
            DT_BYTE: return 1'b0;
            DT_HALF: return a == 2'd3;
            default: return a != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes on both ports plus the memory-side bus.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        dtype0, dtype1;
    logic              gnt0, gnt1, done0, done1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        mem_datatype;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dtype0, dtype1, mem_rdata,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_read, mem_write, mem_addr, mem_wdata, mem_datatype
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dtype0, dtype1, mem_rdata,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_read, mem_write, mem_addr, mem_wdata, mem_datatype
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way winner select, win = 1 selects port 1.
// DMEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win
);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign win = req1 && !req0;
`else
    // On a tie the port that was not served last goes next.
    assign win = (req0 && req1) ? !last : req1;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between two requesters, one access at a time.
// Optional DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_pick) gives port 0 fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    st_e               state;
    logic              last, own, win, l_we, l_mis, load_ok;
    logic [DATA_W-1:0] rhold0, rhold1;
    logic              sel_we, sel_mis;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_dt;

    dmem_rr_pick u_pick (.req0(bus.req0), .req1(bus.req1), .last(last), .win(win));

    always_comb begin
        sel_we    = win ? bus.we1    : bus.we0;
        sel_addr  = win ? bus.addr1  : bus.addr0;
        sel_wdata = win ? bus.wdata1 : bus.wdata0;
        sel_dt    = win ? bus.dtype1 : bus.dtype0;
        sel_mis   = misaligned(sel_dt, sel_addr[1:0]);
    end

    // Memory registers read data at the end of ISSUE, so it is forwarded
    // straight through in RESP and captured for holding at the end of RESP.
    assign load_ok    = (state == ST_RESP) && !l_we && !l_mis;
    assign bus.rdata0 = (load_ok && !own) ? bus.mem_rdata : rhold0;
    assign bus.rdata1 = (load_ok &&  own) ? bus.mem_rdata : rhold1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            last             <= 1'(RR_INIT);
            own              <= 1'b0;
            l_we             <= 1'b0;
            l_mis            <= 1'b0;
            rhold0           <= '0;
            rhold1           <= '0;
            bus.gnt0         <= 1'b0;
            bus.gnt1         <= 1'b0;
            bus.done0        <= 1'b0;
            bus.done1        <= 1'b0;
            bus.err0         <= 1'b0;
            bus.err1         <= 1'b0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_datatype <= 2'd0;
        end else begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    bus.done0 <= !own;
                    bus.done1 <= own;
                    bus.err0  <= !own && l_mis;
                    bus.err1  <= own && l_mis;
                    last      <= own;
                    state     <= ST_RESP;
                end
                default: begin
                    // IDLE and RESP both arbitrate, giving back-to-back service.
                    if (load_ok) begin
                        if (own) rhold1 <= bus.mem_rdata;
                        else     rhold0 <= bus.mem_rdata;
                    end
                    if (bus.req0 || bus.req1) begin
                        own              <= win;
                        l_we             <= sel_we;
                        l_mis            <= sel_mis;
                        bus.gnt0         <= !win;
                        bus.gnt1         <= win;
                        bus.mem_addr     <= sel_addr;
                        bus.mem_wdata    <= sel_wdata;
                        bus.mem_datatype <= sel_dt;
                        bus.mem_write    <= sel_we && !sel_mis;
                        bus.mem_read     <= !sel_we && !sel_mis;
                        state            <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, corner sequences and a random run against a transaction model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam logic [31:0] DEF = 32'h0BAD_F00D;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_INIT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Memory stub: stores whole wdata keyed by byte address, registers read data.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_read) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : DEF;
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dt;
        logic        exp_err;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] dt);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.dtype0 = dt;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.dtype1 = dt;
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_read, bus.mem_write};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int   n;
        logic g;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.dt);
        n = 0;
        g = 1'b0;
        while (!g && n < 4) begin
            @(negedge clk);
            n++;
            g = (v.port == 1) ? bus.gnt1 : bus.gnt0;
        end
        chk("txn_latency", 64'(n), 64'(1));
        chk("txn_gnt_cycle", 64'(ctl()), 64'({v.port == 0, v.port == 1, 2'b00, v.exp_rd, v.exp_wr}));
        chk("txn_mem_addr", 64'(bus.mem_addr), 64'(v.addr));
        chk("txn_mem_data", 64'({bus.mem_wdata, bus.mem_datatype}), 64'({v.wdata, v.dt}));
        drive(v.port, 1'b0, v.we, v.addr, v.wdata, v.dt);
        @(negedge clk);
        chk("txn_done_cycle", 64'(ctl()), 64'({2'b00, v.port == 0, v.port == 1, 2'b00}));
        chk("txn_err", 64'({bus.err0, bus.err1}),
            64'({v.port == 0 && v.exp_err, v.port == 1 && v.exp_err}));
        chk("txn_rdata", 64'((v.port == 1) ? bus.rdata1 : bus.rdata0), 64'(v.exp_rdata));
        @(negedge clk);
    endtask

    function automatic logic mis_ref(input logic [1:0] dt, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        return (dt == 2'd1 && off == 3) || (dt >= 2'd2 && off != 0);
    endfunction

    // Random-phase requester state and transaction-level model.
    logic        r [2];
    logic        rwe [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];
    logic [1:0]  rdt [2];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] hold [2];

    initial begin
        int          gport [5];
        logic [5:0]  exp_ctl;
        logic [1:0]  exp_err;
        logic [31:0] eaddr, ewd, aval;
        logic [1:0]  edt;
        logic        acc, amis, aload, g;
        int          aport, p, mlast, blocked;

        tbl[0]  = '{0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
        tbl[1]  = '{0, 1'b0, 32'h8000_0004, 32'h0000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1, 1'b0, 32'h8000_0004, 32'h0000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[3]  = '{1, 1'b0, 32'h8000_0002, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{0, 1'b1, 32'h8000_0013, 32'h0000_5555, 2'd1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[5]  = '{0, 1'b1, 32'h8000_0013, 32'h0000_00AB, 2'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[6]  = '{0, 1'b0, 32'h8000_0013, 32'h0000_0000, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_00AB};
        tbl[7]  = '{1, 1'b0, 32'h8000_0011, 32'h0000_0000, 2'd1, 1'b0, 1'b1, 1'b0, DEF};
        tbl[8]  = '{1, 1'b1, 32'h8000_0006, 32'h0000_1234, 2'd1, 1'b0, 1'b0, 1'b1, DEF};
        tbl[9]  = '{0, 1'b0, 32'h8000_0001, 32'h0000_0000, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0000_00AB};
        tbl[10] = '{0, 1'b0, 32'h8000_0010, 32'h0000_0000, 2'd3, 1'b0, 1'b1, 1'b0, DEF};

        do_reset();
        chk("rst_ctl", 64'({ctl(), bus.err0, bus.err1}), 64'(0));
        chk("rst_bus", 64'({bus.mem_addr, bus.mem_datatype}), 64'(0));
        chk("rst_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_rdata", {bus.rdata0, bus.rdata1}, 64'(0));

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // Both ports held: alternating grants (fixed priority: port 0 until it drops).
        do_reset();
        if (FIXED) gport = '{0, 0, 0, 0, 1};
        else       gport = '{0, 1, 0, 1, 1};
        drive(0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 2'd2);
        drive(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                p = gport[(c - 1) / 2];
                chk("rr_gnt", 64'(ctl()), 64'({p == 0, p == 1, 2'b00, 1'b1, 1'b0}));
            end else begin
                p = gport[(c - 2) / 2];
                chk("rr_done", 64'(ctl()), 64'({2'b00, p == 0, p == 1, 2'b00}));
            end
            if (c == 8) bus.req0 = 1'b0;
            if (c == 9) bus.req1 = 1'b0;
        end
        @(negedge clk);

        // Reset during ISSUE of a store drops the transaction.
        drive(0, 1'b1, 1'b1, 32'h8000_0020, 32'h1111_2222, 2'd2);
        @(negedge clk);
        chk("rst_mid_issue", 64'(ctl()), 64'(6'b100001));
        drive(0, 1'b0, 1'b1, 32'h8000_0020, 32'h1111_2222, 2'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_after", 64'({ctl(), bus.err0, bus.err1}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_nodone", 64'({ctl(), bus.rdata0}), 64'(0));
        run_txn('{0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF});

        // Random traffic against the transaction model.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            r[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = 32'h0; rwd[i] = 32'h0; rdt[i] = 2'd0; hold[i] = 32'h0;
        end
        mlast = 1; blocked = 0; acc = 1'b0; aport = 0; amis = 1'b0; aload = 1'b0; aval = 32'h0;
        exp_ctl = '0; exp_err = '0; eaddr = '0; ewd = '0; edt = '0;
        for (int k = 0; k < 600; k++) begin
            chk("rnd_ctl", 64'(ctl()), 64'(exp_ctl));
            if (exp_ctl[5] || exp_ctl[4])
                chk("rnd_bus", 64'({bus.mem_addr, bus.mem_wdata[29:0], bus.mem_datatype}),
                    64'({eaddr, ewd[29:0], edt}));
            if (exp_ctl[3] || exp_ctl[2]) chk("rnd_err", 64'({bus.err0, bus.err1}), 64'(exp_err));
            chk("rnd_rdata", {bus.rdata0, bus.rdata1}, {hold[0], hold[1]});

            for (int q = 0; q < 2; q++) begin
                g = (q == 1) ? bus.gnt1 : bus.gnt0;
                if (g) begin
                    r[q] = 1'($urandom_range(0, 1));
                end else if (r[q]) begin
                    if ($urandom_range(0, 15) == 0) r[q] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    r[q] = 1'b1;
                end
                if (r[q] && (g || ((q == 1) ? !bus.req1 : !bus.req0))) begin
                    rwe[q]   = 1'($urandom_range(0, 1));
                    raddr[q] = 32'h9000_0000 + 32'($urandom_range(0, 31));
                    rwd[q]   = $urandom;
                    rdt[q]   = 2'($urandom_range(0, 3));
                end
                drive(q, r[q], rwe[q], raddr[q], rwd[q], rdt[q]);
            end

            // Outcome of the coming edge k+1.
            exp_ctl = '0;
            exp_err = '0;
            if (acc) begin
                exp_ctl[3 - aport] = 1'b1;
                exp_err[1 - aport] = amis;
                if (aload && !amis) hold[aport] = aval;
                acc = 1'b0;
            end
            if (k + 1 >= blocked && (r[0] || r[1])) begin
                if (r[0] && r[1]) p = FIXED ? 0 : ((mlast == 0) ? 1 : 0);
                else              p = r[0] ? 0 : 1;
                aport = p;
                amis  = mis_ref(rdt[p], raddr[p]);
                aload = !rwe[p];
                if (aload && !amis) aval = ref_mem.exists(raddr[p]) ? ref_mem[raddr[p]] : DEF;
                if (!aload && !amis) ref_mem[raddr[p]] = rwd[p];
                exp_ctl[5 - p] = 1'b1;
                exp_ctl[1] = aload && !amis;
                exp_ctl[0] = !aload && !amis;
                eaddr = raddr[p]; ewd = rwd[p]; edt = rdt[p];
                mlast = p;
                blocked = k + 3;
                acc = 1'b1;
            end
            @(negedge clk);
        end

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/DMA/debug master).
- Arbitrates round-robin and issues one access at a time on the memory-side read/write/address/data/datatype bus.
- Returns registered read data with a done pulse.
- Rejects misaligned accesses without touching memory.

Parameters:
- ADDR_W, 32, address width of requester and memory buses
- DATA_W, 32, data width of write and read data
- RR_INIT, 1, value of the last-granted pointer after reset (1 means port 0 wins the first tie)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- req0, req1  in  1 each  request; held high with stable fields until the matching gnt
- we0, we1  in  1 each  1 = store, 0 = load
- addr0, addr1  in  ADDR_W each  byte address
- wdata0, wdata1  in  DATA_W each  store data
- dtype0, dtype1  in  2 each  0 = byte, 1 = half, 2 or 3 = word
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted
- done0, done1  out  1 each  one-cycle pulse: transaction complete
- err0, err1  out  1 each  valid with done: misaligned, no memory access made
- rdata0, rdata1  out  DATA_W each  load data, valid with done
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_datatype  out  2  memory access size
- mem_rdata  in  DATA_W  memory read data, registered by memory at the posedge ending the access cycle

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE, last = RR_INIT.
  - All gnt, done, err, mem_read and mem_write = 0.
  - mem_addr, mem_wdata, rdata0 and rdata1 = 0; mem_datatype = 0.
  - Reset mid-transaction drops that transaction: no done is issued and no write occurs after the reset edge.
- States:
  - IDLE: no access in progress.
  - ISSUE: memory strobes driven for exactly one cycle.
  - RESP: done/err pulsed to the owner.
- IDLE:
  - At a posedge with req0 or req1 high, select a winner, latch its we/addr/wdata/dtype and owner id, go to ISSUE.
  - Winner selection: if both requests are high, take the port not equal to last. Otherwise take the only requester.
- ISSUE (1 cycle):
  - gnt of the owner is high.
  - mem_addr, mem_wdata and mem_datatype come from the latched values.
  - If the access is aligned: mem_write = we, mem_read = !we.
  - If misaligned, both strobes stay 0. Misaligned means word with addr[1:0] != 0, or half with addr[1:0] == 3.
  - Next state RESP; last = owner.
- RESP (1 cycle):
  - done of the owner is high; err = misaligned flag.
  - For an aligned load, rdata of the owner = mem_rdata; it is held until that port's next done.
  - For a store or error, rdata is unchanged.
  - If any req is high, arbitrate as in IDLE and go directly to ISSUE; otherwise go to IDLE.
- Latency and throughput:
  - Request sampled at edge N, gnt during cycle N+1, done during cycle N+2.
  - Sustained throughput is one transaction per 2 cycles.
- Exclusivity:
  - Never more than one gnt or done high at once.
  - mem_read and mem_write are never high together.
- A requester that drops req before gnt is not served; an already-latched request still completes.
- Starvation bound: with both ports continuously requesting, grants alternate 0,1,0,1.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a simultaneous request; last is still updated but ignored for selection, and port 1 may starve.
- Undefined: round-robin as above.

Decomposition:
- Shared package dmem_pkg holds:
  - Datatype constants DT_BYTE = 0, DT_HALF = 1, DT_WORD = 2.
  - State encodings ST_IDLE, ST_ISSUE, ST_RESP.
  - Misaligned-check function on (dtype, addr[1:0]).
- One sub-module, dmem_rr_pick: combinational two-way picker with inputs req0, req1, last and output win, plus the fixed-priority variant under the macro.

Test Plan:
- Reset then single store on port 0 (addr 0x80000004, wdata 0xDEADBEEF, dtype 2):
  - gnt0 in cycle 1 with mem_write = 1, mem_addr = 0x80000004.
  - done0 in cycle 2 with err0 = 0.
  - Follow with a load from the same address: rdata0 = 0xDEADBEEF in the done0 cycle.
- req0 and req1 high simultaneously after reset, held for 4 transactions:
  - Grant order 0,1,0,1.
  - gnt and done never overlap between ports; a transaction every 2 cycles.
- Misaligned word load on port 1 (addr 0x80000002, dtype 2):
  - mem_read stays 0 throughout.
  - done1 = 1 with err1 = 1; rdata1 unchanged.
- Half store at addr[1:0] = 3 on port 0 -> err0 = 1 and no mem_write. Byte store at addr[1:0] = 3 -> accepted with err0 = 0.
- rst_n asserted during ISSUE of a store -> next cycle state IDLE, mem_write = 0, no done; a new req0 afterwards is served normally.
- With DMEM_ARB_FIXED_PRIO_EN defined, both requests held -> port 0 granted every transaction and port 1 never granted until req0 drops.
